// File: rtl/alu_arbiter.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin front end sharing one combinational 8-bit ALU
//               between two requesters, with multicycle multiply window.
// Revision    : 1.0
// ============================================================================

module alu_arbiter #(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_opcode,
  input  logic [7:0]       req0_in1,
  input  logic [7:0]       req0_in2,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_opcode,
  input  logic [7:0]       req1_in1,
  input  logic [7:0]       req1_in2,

  output logic [3:0]       alu_opcode,
  output logic [7:0]       alu_in1,
  output logic [7:0]       alu_in2,
  input  logic [15:0]      alu_result,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic             rsp_id,
  output logic             rsp_err,

  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] OP_MUL   = 4'b0010;
  localparam logic [3:0] OP_UNDEF = 4'b1111;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  logic [1:0] state;
  logic       rr_ptr;
  logic [3:0] exec_cnt;

  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       sel_id;
  logic [3:0] sel_opcode;
  logic [7:0] sel_in1;
  logic [7:0] sel_in2;

  // A lone valid always wins; on contention rr_ptr picks the requester.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~rr_ptr);
    grant1 = req1_valid & (~req0_valid |  rr_ptr);
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    sel_id     = req1_ready;
    sel_opcode = req1_ready ? req1_opcode : req0_opcode;
    sel_in1    = req1_ready ? req1_in1    : req0_in1;
    sel_in2    = req1_ready ? req1_in2    : req0_in2;
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      exec_cnt   <= 4'd0;
      alu_opcode <= 4'd0;
      alu_in1    <= 8'd0;
      alu_in2    <= 8'd0;
      rsp_result <= 16'd0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_opcode <= sel_opcode;
            alu_in1    <= sel_in1;
            alu_in2    <= sel_in2;
            rsp_id     <= sel_id;
            rr_ptr     <= ~sel_id;
            exec_cnt   <= (sel_opcode == OP_MUL) ? MUL_LOAD : 4'd0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (exec_cnt == 4'd0) begin
            rsp_result <= alu_result;
            rsp_err    <= (alu_opcode == OP_UNDEF);
            state      <= RESP;
          end else begin
            exec_cnt <= exec_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            ops_done <= ops_done + 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Scoreboard bench for alu_arbiter with a reference ALU model.
// Revision    : 1.0
// ============================================================================

module tb_alu_arbiter;

  localparam int MUL_CYCLES = 2;
  localparam int CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [3:0]       req0_opcode, req1_opcode;
  logic [7:0]       req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]       alu_opcode;
  logic [7:0]       alu_in1, alu_in2;
  logic [15:0]      alu_result;
  logic             rsp_valid, rsp_ready;
  logic [15:0]      rsp_result;
  logic             rsp_id, rsp_err;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy), .ops_done(ops_done)
  );

  // Stand-in for the external combinational ALU; 4'b1111 returns 0.
  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      4'd0:    alu_f = {8'd0, a} + {8'd0, b};
      4'd1:    alu_f = {8'd0, a} - {8'd0, b};
      4'd2:    alu_f = {8'd0, a} * {8'd0, b};
      4'd3:    alu_f = {8'd0, a & b};
      4'd4:    alu_f = {8'd0, a | b};
      4'd5:    alu_f = {8'd0, a ^ b};
      default: alu_f = 16'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_in1, alu_in2);

  typedef struct {
    logic [15:0] res;
    logic        id;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic        acc_log[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_cnt = 0;
  int          exp_ops = 0;
  logic        prev_valid = 1'b0;
  logic [17:0] held;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input logic id, input logic [3:0] op,
                                  input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.res = alu_f(op, a, b);
    e.id  = id;
    e.err = (op == 4'b1111);
    e.acc = cyc;
    e.lat = (op == 4'b0010) ? 1 + MUL_CYCLES : 2;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Negedge monitor: scoreboard push on accept, pop/compare on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("ready_excl", {31'd0, req0_ready & req1_ready}, 32'd0);
      check_eq("ops_done", {{(32-CNT_W){1'b0}}, ops_done}, exp_ops);
      if (rsp_valid && !prev_valid) begin
        check_eq("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) check_eq("latency", cyc - sb[0].acc, sb[0].lat);
        held = {rsp_result, rsp_id, rsp_err};
      end
      if (rsp_valid && prev_valid) begin
        check_eq("rsp_stable", {14'd0, rsp_result, rsp_id, rsp_err}, {14'd0, held});
        check_eq("resp_busy", {31'd0, busy}, 32'd1);
        check_eq("resp_noacc", {31'd0, req0_ready | req1_ready}, 32'd0);
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("rsp_result", {16'd0, rsp_result}, {16'd0, e.res});
        check_eq("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        exp_ops = (exp_ops + 1) % (1 << CNT_W);
      end
      if (req0_valid && req0_ready) begin
        sb.push_back(mk_exp(1'b0, req0_opcode, req0_in1, req0_in2));
        acc_log.push_back(1'b0);
        acc_cnt++;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(mk_exp(1'b1, req1_opcode, req1_in1, req1_in2));
        acc_log.push_back(1'b1);
        acc_cnt++;
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic wait_acc(input int target);
    for (int i = 0; i < 200 && acc_cnt < target; i++) @(posedge clk);
    check_eq("accept_seen", acc_cnt >= target, 32'd1);
    #1;
  endtask

  task automatic drain();
    int ok;
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !busy) ok = 1;
    end
    check_eq("drained", ok, 32'd1);
  endtask

  task automatic issue(input logic id, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    int target;
    target = acc_cnt + 1;
    @(posedge clk);
    #1;
    if (id) begin
      req1_valid = 1'b1; req1_opcode = op; req1_in1 = a; req1_in2 = b;
    end else begin
      req0_valid = 1'b1; req0_opcode = op; req0_in1 = a; req0_in2 = b;
    end
    wait_acc(target);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, "_ops_done"}, {{(32-CNT_W){1'b0}}, ops_done}, 32'd0);
    check_eq({tag, "_alu"}, {12'd0, alu_opcode, alu_in1, alu_in2}, 32'd0);
    check_eq({tag, "_rsp"}, {14'd0, rsp_result, rsp_id, rsp_err}, 32'd0);
    check_eq({tag, "_ready"}, {30'd0, req0_ready, req1_ready}, 32'd0);
  endtask

  initial begin
    int n0;
    int ops_before;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_opcode = 4'd0; req0_in1 = 8'd0; req0_in2 = 8'd0;
    req1_valid = 1'b0; req1_opcode = 4'd0; req1_in1 = 8'd0; req1_in2 = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_reset_outputs("por");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    // Single add, then multiply from requester 1.
    issue(1'b0, 4'd0, 8'h05, 8'h03);
    drain();
    check_eq("t1_ops", {{(32-CNT_W){1'b0}}, ops_done}, 32'd1);
    issue(1'b1, 4'd2, 8'hFF, 8'hFF);
    drain();

    // Fairness: both requesters valid for four operations.
    n0 = acc_log.size();
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_opcode = 4'd1; req0_in1 = 8'h10; req0_in2 = 8'h20;
    req1_valid = 1'b1; req1_opcode = 4'd5; req1_in1 = 8'h5A; req1_in2 = 8'hC3;
    wait_acc(acc_cnt + 4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
    for (int k = 0; k < 4; k++)
      check_eq("rr_order", (n0 + k < acc_log.size()) ? {31'd0, acc_log[n0 + k]} : 32'hDEAD,
               k % 2);

    // Back-pressure: hold rsp_ready low for five RESP cycles.
    rsp_ready = 1'b0;
    issue(1'b0, 4'd3, 8'hA5, 8'h3C);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
    req1_valid = 1'b1; req1_opcode = 4'd0; req1_in1 = 8'h01; req1_in2 = 8'h01;
    repeat (5) @(posedge clk);
    #1;
    check_eq("bp_busy", {31'd0, busy}, 32'd1);
    req1_valid = 1'b0;
    ops_before = int'(ops_done);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_idle", {31'd0, busy}, 32'd0);
    check_eq("bp_ops_inc", {{(32-CNT_W){1'b0}}, ops_done}, ops_before + 1);
    drain();

    // Undefined opcode, then a normal op.
    issue(1'b1, 4'hF, 8'h12, 8'h34);
    drain();
    issue(1'b0, 4'd0, 8'h01, 8'h02);
    drain();

    // Reset mid-EXEC of a multiply.
    issue(1'b0, 4'd2, 8'h0C, 8'h0B);
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    check_reset_outputs("arst");
    sb.delete();
    exp_ops = 0;
    prev_valid = 1'b0;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    rst_n = 1'b1;
    issue(1'b1, 4'd4, 8'h0F, 8'hF0);
    drain();
    check_eq("post_rst_ops", {{(32-CNT_W){1'b0}}, ops_done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
